// File: rtl/mac_rx_pkg.sv
// Shared constants, FSM encoding and helpers for the RX MAC frame checker.
package mac_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StHdr,
        StPay,
        StDrop
    } rx_state_e;

    localparam logic [7:0]  C_PREAMBLE    = 8'h55;
    localparam logic [7:0]  C_SFD         = 8'hD5;
    localparam logic [47:0] C_BCAST_MAC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] C_CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] C_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] C_CRC_RESIDUE = 32'hDEBB_20E3;

    localparam int unsigned C_HDR_LEN   = 14;
    localparam int unsigned C_FCS_LEN   = 4;
    localparam int unsigned C_MIN_LEN   = 19;
    // One payload byte plus the FCS must be held before anything is known to be payload.
    localparam int unsigned C_SR_DEPTH  = C_FCS_LEN + 1;

    // Saturating 16-bit increment for the drop counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) next-state for one byte per cycle.
module crc32_d8
    import mac_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // LSB-first shift of the byte through the reflected polynomial.
    always_comb begin
        crc_next = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ C_CRC_POLY) : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/mac_rx_frame_check.sv
// RX MAC front end: strips preamble/SFD, filters on destination MAC, extracts source MAC and
// EtherType, streams payload with the FCS removed and flags frame status on the last byte.
// Optional feature macro: MAC_RX_CRC_CHECK_EN (CRC-32 check of dst..FCS; without it the FCS is
// only stripped and o_frame_err reports oversize only).
module mac_rx_frame_check
    import mac_rx_pkg::*;
#(
    parameter int unsigned P_MAX_LEN      = 1522,
    parameter bit          P_ACCEPT_BCAST = 1'b1
) (
    input  logic        i_udp_stack_clk,
    input  logic        i_rst_n,
    input  logic [47:0] i_local_mac,
    input  logic [7:0]  i_gmii_rx_data,
    input  logic        i_gmii_rx_valid,
    output logic [7:0]  o_mac_rx_data,
    output logic        o_mac_rx_valid,
    output logic        o_mac_rx_last,
    output logic [15:0] o_mac_rx_type,
    output logic [47:0] o_mac_rx_src_mac,
    output logic        o_frame_ok,
    output logic        o_frame_err,
    output logic [15:0] o_drop_cnt
);

    localparam logic [10:0] MaxLen = 11'(P_MAX_LEN);

    rx_state_e   state_q;
    logic [2:0]  pre_cnt_q;
    logic [10:0] cnt_q;
    logic [47:0] hdr_q;
    logic [7:0]  sr_q [C_SR_DEPTH];
    logic [2:0]  held_q;
    logic        emitted_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        last_q;
    logic        ok_q;
    logic        err_q;
    logic [15:0] type_q;
    logic [47:0] src_q;
    logic [15:0] drop_q;

    logic [47:0] dst_word;
    logic        dst_hit;
    logic        crc_good;

    // Destination is complete once its 6th byte is on the input.
    assign dst_word = {hdr_q[39:0], i_gmii_rx_data};
    assign dst_hit  = (dst_word == i_local_mac) || (P_ACCEPT_BCAST && (dst_word == C_BCAST_MAC));

`ifdef MAC_RX_CRC_CHECK_EN
    logic [31:0] crc_q;
    logic [31:0] crc_next;

    crc32_d8 u_crc32_d8 (
        .crc      (crc_q),
        .data     (i_gmii_rx_data),
        .crc_next (crc_next)
    );

    // Running CRC over every byte after the SFD, restarted at each SFD.
    always_ff @(posedge i_udp_stack_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crc_q <= C_CRC_INIT;
        end else if (state_q == StPre && i_gmii_rx_valid && i_gmii_rx_data == C_SFD) begin
            crc_q <= C_CRC_INIT;
        end else if (i_gmii_rx_valid && (state_q == StHdr || state_q == StPay)) begin
            crc_q <= crc_next;
        end
    end

    assign crc_good = (crc_q == C_CRC_RESIDUE);
`else
    assign crc_good = 1'b1;
`endif

    // Frame FSM with registered payload stream, status pulses and drop counter.
    always_ff @(posedge i_udp_stack_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // Resetting into StDrop discards the tail of any frame still in flight at release;
            // with valid low it falls through to StIdle on the first clock.
            state_q   <= StDrop;
            pre_cnt_q <= '0;
            cnt_q     <= '0;
            hdr_q     <= '0;
            held_q    <= '0;
            emitted_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            type_q    <= '0;
            src_q     <= '0;
            drop_q    <= '0;
            for (int i = 0; i < C_SR_DEPTH; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_gmii_rx_valid) begin
                        if (i_gmii_rx_data == C_PREAMBLE) begin
                            state_q   <= StPre;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q <= StDrop;
                            drop_q  <= sat_inc(drop_q);
                        end
                    end
                end
                StPre: begin
                    if (!i_gmii_rx_valid) begin
                        state_q <= StIdle;
                        drop_q  <= sat_inc(drop_q);
                    end else if (i_gmii_rx_data == C_SFD) begin
                        state_q   <= StHdr;
                        cnt_q     <= '0;
                        held_q    <= '0;
                        emitted_q <= 1'b0;
                    end else if (i_gmii_rx_data == C_PREAMBLE && pre_cnt_q < 3'd7) begin
                        pre_cnt_q <= pre_cnt_q + 3'd1;
                    end else begin
                        state_q <= StDrop;
                        drop_q  <= sat_inc(drop_q);
                    end
                end
                StHdr: begin
                    if (!i_gmii_rx_valid) begin
                        state_q <= StIdle;
                        drop_q  <= sat_inc(drop_q);
                    end else if (cnt_q == MaxLen) begin
                        state_q <= StDrop;
                        drop_q  <= sat_inc(drop_q);
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                        hdr_q <= {hdr_q[39:0], i_gmii_rx_data};
                        // cnt_q is the number of header bytes already taken
                        if (cnt_q == 11'd5 && !dst_hit) begin
                            state_q <= StDrop;
                            drop_q  <= sat_inc(drop_q);
                        end
                        if (cnt_q == 11'd12) begin
                            src_q <= hdr_q;
                        end
                        if (cnt_q == 11'(C_HDR_LEN - 1)) begin
                            type_q  <= {hdr_q[7:0], i_gmii_rx_data};
                            state_q <= StPay;
                        end
                    end
                end
                StPay: begin
                    if (!i_gmii_rx_valid) begin
                        if (cnt_q < 11'(C_MIN_LEN)) begin
                            drop_q <= sat_inc(drop_q);
                        end else begin
                            data_q  <= sr_q[0];
                            valid_q <= 1'b1;
                            last_q  <= 1'b1;
                            ok_q    <= crc_good;
                            err_q   <= !crc_good;
                        end
                        state_q <= StIdle;
                        held_q  <= '0;
                    end else if (cnt_q == MaxLen) begin
                        if (emitted_q) begin
                            data_q  <= sr_q[0];
                            valid_q <= 1'b1;
                            last_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            drop_q <= sat_inc(drop_q);
                        end
                        state_q <= StDrop;
                        held_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 11'd1;
                        if (held_q == 3'(C_SR_DEPTH)) begin
                            data_q    <= sr_q[0];
                            valid_q   <= 1'b1;
                            emitted_q <= 1'b1;
                            for (int i = 0; i < C_SR_DEPTH - 1; i++) begin
                                sr_q[i] <= sr_q[i+1];
                            end
                            sr_q[C_SR_DEPTH-1] <= i_gmii_rx_data;
                        end else begin
                            sr_q[held_q] <= i_gmii_rx_data;
                            held_q       <= held_q + 3'd1;
                        end
                    end
                end
                StDrop: begin
                    if (!i_gmii_rx_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_mac_rx_data    = data_q;
    assign o_mac_rx_valid   = valid_q;
    assign o_mac_rx_last    = last_q;
    assign o_mac_rx_type    = type_q;
    assign o_mac_rx_src_mac = src_q;
    assign o_frame_ok       = ok_q;
    assign o_frame_err      = err_q;
    assign o_drop_cnt       = drop_q;

endmodule

// File: tb/tb_mac_rx_frame_check.sv
// Randomised self-checking bench for mac_rx_frame_check with a frame-level reference model.
module tb_mac_rx_frame_check;

    localparam int MaxLen = 1522;
    localparam logic [47:0] LocalMac = 48'h02_00_5E_10_20_30;
    localparam logic [47:0] BcastMac = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SrcMac   = 48'h00_0A_35_01_02_03;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  o_mac_rx_data;
    logic        o_mac_rx_valid;
    logic        o_mac_rx_last;
    logic [15:0] o_mac_rx_type;
    logic [47:0] o_mac_rx_src_mac;
    logic        o_frame_ok;
    logic        o_frame_err;
    logic [15:0] o_drop_cnt;

    always #5 clk = ~clk;

    mac_rx_frame_check #(
        .P_MAX_LEN      (MaxLen),
        .P_ACCEPT_BCAST (1'b1)
    ) dut (
        .i_udp_stack_clk  (clk),
        .i_rst_n          (rst_n),
        .i_local_mac      (LocalMac),
        .i_gmii_rx_data   (rx_data),
        .i_gmii_rx_valid  (rx_valid),
        .o_mac_rx_data    (o_mac_rx_data),
        .o_mac_rx_valid   (o_mac_rx_valid),
        .o_mac_rx_last    (o_mac_rx_last),
        .o_mac_rx_type    (o_mac_rx_type),
        .o_mac_rx_src_mac (o_mac_rx_src_mac),
        .o_frame_ok       (o_frame_ok),
        .o_frame_err      (o_frame_err),
        .o_drop_cnt       (o_drop_cnt)
    );

    typedef struct {
        logic [7:0]  d;
        logic        last;
        logic        ok;
        logic        err;
        logic [15:0] t;
        logic [47:0] s;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] body[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         model_drop = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial IEEE 802.3 FCS over body[0..n-1].
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                logic fb = c[0] ^ body[i][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                         input int pay_len, input bit inc_pay, input bit corrupt);
        logic [31:0] f;
        body.delete();
        for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(src[47-8*i -: 8]);
        body.push_back(et[15:8]);
        body.push_back(et[7:0]);
        for (int i = 0; i < pay_len; i++) body.push_back(inc_pay ? 8'(i) : 8'($urandom));
        f = fcs_of(body.size());
        body.push_back(f[7:0]);
        body.push_back(f[15:8]);
        body.push_back(f[23:16]);
        body.push_back(f[31:24]);
        if (corrupt) body[body.size()-1] = body[body.size()-1] ^ 8'h01;
    endtask

    task automatic drop_inc();
        if (model_drop < 65535) model_drop++;
    endtask

    task automatic push_pay(input int first, input int lastidx, input bit ok, input bit err,
                            input logic [15:0] t, input logic [47:0] s);
        exp_t e;
        for (int i = first; i <= lastidx; i++) begin
            e.d    = body[i];
            e.last = (i == lastidx);
            e.ok   = (i == lastidx) && ok;
            e.err  = (i == lastidx) && err;
            e.t    = t;
            e.s    = s;
            exp_q.push_back(e);
        end
    endtask

    // Frame-level expectation: what a receiver must emit for this preamble and body.
    task automatic model_frame(input int pre_n, input bit sfd, output bit normal_end);
        int          len;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        logic [31:0] fcs;
        bit          good;
        len = body.size();
        normal_end = 1'b0;
        if (pre_n < 1 || pre_n > 7 || !sfd || len < 6) begin
            drop_inc();
            return;
        end
        dst = {body[0], body[1], body[2], body[3], body[4], body[5]};
        if (dst != LocalMac && dst != BcastMac) begin
            drop_inc();
            return;
        end
        if (len > MaxLen) begin
            src = {body[6], body[7], body[8], body[9], body[10], body[11]};
            et  = {body[12], body[13]};
            if (MaxLen >= 20) push_pay(14, MaxLen - 5, 1'b0, 1'b1, et, src);
            else drop_inc();
            return;
        end
        if (len < 19) begin
            drop_inc();
            return;
        end
        src = {body[6], body[7], body[8], body[9], body[10], body[11]};
        et  = {body[12], body[13]};
        fcs = {body[len-1], body[len-2], body[len-3], body[len-4]};
`ifdef MAC_RX_CRC_CHECK_EN
        good = (fcs_of(len - 4) == fcs);
`else
        good = 1'b1;
`endif
        push_pay(14, len - 5, good, !good, et, src);
        normal_end = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic run_frame(input int pre_n, input bit sfd, input int gap, input int rst_at);
        bit el = 1'b0;
        if (rst_at < 0) model_frame(pre_n, sfd, el);
        else model_drop = 0;
        for (int i = 0; i < pre_n; i++) send(8'h55);
        if (sfd) send(8'hD5);
        for (int i = 0; i < body.size(); i++) begin
            send(body[i]);
            if (i == rst_at) begin
                #2;
                rst_n = 1'b0;
            end
            if (rst_at >= 0 && i == rst_at + 3) rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (gap >= 2) begin
            @(negedge clk);
            @(negedge clk);
            if (el) check_val("last_latency", 64'(o_mac_rx_last), 64'd1);
            repeat (gap - 2) @(posedge clk);
        end
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
        check_val("drop_cnt", 64'(o_drop_cnt), 64'(model_drop));
    endtask

    // Scoreboard: every emitted byte must match the head of the expected stream.
    always @(negedge clk) begin
        if (o_mac_rx_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_byte", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("rx_data", 64'(o_mac_rx_data), 64'(mon_e.d));
                check_val("rx_last", 64'(o_mac_rx_last), 64'(mon_e.last));
                check_val("frame_ok", 64'(o_frame_ok), 64'(mon_e.ok));
                check_val("frame_err", 64'(o_frame_err), 64'(mon_e.err));
                check_val("rx_type", 64'(o_mac_rx_type), 64'(mon_e.t));
                check_val("rx_src", 64'(o_mac_rx_src_mac), 64'(mon_e.s));
            end
        end else if (o_mac_rx_last || o_frame_ok || o_frame_err) begin
            check_val("stray_status", 64'({o_mac_rx_last, o_frame_ok, o_frame_err}), 64'd0);
        end
    end

    initial begin
        logic [47:0] dst;
        int          r;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_valid", 64'(o_mac_rx_valid), 64'd0);
        check_val("rst_status", 64'({o_mac_rx_last, o_frame_ok, o_frame_err}), 64'd0);
        check_val("rst_drop", 64'(o_drop_cnt), 64'd0);
        check_val("rst_type_src", 64'({o_mac_rx_type, o_mac_rx_src_mac}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Good unicast frame, then same frame with a damaged FCS.
        build(LocalMac, SrcMac, 16'h0800, 46, 1'b1, 1'b0);
        run_frame(7, 1'b1, 4, -1);
        settle();
        build(LocalMac, SrcMac, 16'h0800, 46, 1'b1, 1'b1);
        run_frame(7, 1'b1, 4, -1);
        settle();

        // Broadcast accepted, foreign unicast dropped.
        build(BcastMac, SrcMac, 16'h0806, 28, 1'b0, 1'b0);
        run_frame(7, 1'b1, 3, -1);
        build(48'h11_22_33_44_55_66, SrcMac, 16'h0800, 46, 1'b0, 1'b0);
        run_frame(7, 1'b1, 3, -1);
        settle();

        // Runt boundary: 18 bytes after SFD dropped, 19 bytes gives one payload byte.
        build(LocalMac, SrcMac, 16'h0800, 0, 1'b0, 1'b0);
        run_frame(7, 1'b1, 3, -1);
        build(LocalMac, SrcMac, 16'h0800, 1, 1'b0, 1'b0);
        run_frame(7, 1'b1, 3, -1);
        settle();

        // Oversize frame followed back-to-back by a good one.
        build(LocalMac, SrcMac, 16'h86DD, 1582, 1'b0, 1'b0);
        run_frame(7, 1'b1, 1, -1);
        build(LocalMac, SrcMac, 16'h0800, 50, 1'b0, 1'b0);
        run_frame(7, 1'b1, 4, -1);
        settle();

        // Reset at header byte 8, released while valid is still high; next frame must be clean.
        build(LocalMac, SrcMac, 16'h0800, 30, 1'b0, 1'b0);
        run_frame(7, 1'b1, 3, 7);
        settle();
        build(LocalMac, SrcMac, 16'h0800, 30, 1'b0, 1'b0);
        run_frame(5, 1'b1, 3, -1);
        settle();

        // Preamble violations: eight 0x55, SFD without preamble, valid falling mid-preamble.
        build(LocalMac, SrcMac, 16'h0800, 20, 1'b0, 1'b0);
        run_frame(8, 1'b1, 3, -1);
        run_frame(0, 1'b1, 3, -1);
        body.delete();
        run_frame(4, 1'b0, 3, -1);
        settle();

        // Randomised frames: address, length, truncation, FCS damage, preamble length, gap.
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 3));
            dst = (r == 0) ? BcastMac : (r == 1) ? {16'h0A0B, 32'($urandom)} : LocalMac;
            build(dst, {16'h0000, 32'($urandom)}, 16'($urandom), int'($urandom_range(0, 60)),
                  1'b0, ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, body.size()));
                while (body.size() > r) void'(body.pop_back());
            end
            run_frame(int'($urandom_range(1, 7)), 1'b1, int'($urandom_range(1, 3)), -1);
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
